// File: rtl/i2c_arb_pkg.sv
// Shared types and field widths for the I2C master arbiter.
// Imported by the arbiter, its interface and the bench.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT_RDY,
    BUSY,
    RELEASE
  } state_t;

  localparam int NB_W   = 6;
  localparam int DA_W   = 7;
  localparam int BYTE_W = 8;

  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Requester and master-engine signals of the I2C arbiter.
// The master modport is the arbiter side; slave is the environment.
interface i2c_master_arbiter_if #(
  parameter int N_REQ = 2
);
  import i2c_arb_pkg::*;

  logic [N_REQ-1:0]        req_go;
  logic [N_REQ-1:0]        req_rw;
  logic [NB_W*N_REQ-1:0]   req_nbytes;
  logic [DA_W*N_REQ-1:0]   req_dev_add;
  logic [BYTE_W*N_REQ-1:0] req_reg;
  logic [BYTE_W*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]        req_grant;
  logic [N_REQ-1:0]        req_ack;
  logic [N_REQ-1:0]        req_done;
  logic [N_REQ-1:0]        req_err;
  logic [BYTE_W-1:0]       rd_data;

  logic                    m_go;
  logic                    m_rw;
  logic [NB_W-1:0]         m_nbytes;
  logic [DA_W-1:0]         m_dev_add;
  logic [BYTE_W-1:0]       m_reg;
  logic [BYTE_W-1:0]       m_wdata;
  logic                    m_stop;
  logic                    m_ready;
  logic                    m_done;
  logic                    m_ack;
  logic [BYTE_W-1:0]       m_rdata;

  modport master (
    input  req_go, req_rw, req_nbytes,
    input  req_dev_add, req_reg, req_wdata,
    input  m_ready, m_done, m_ack, m_rdata,
    output req_grant, req_ack, req_done,
    output req_err, rd_data,
    output m_go, m_rw, m_nbytes, m_dev_add,
    output m_reg, m_wdata, m_stop
  );

  modport slave (
    output req_go, req_rw, req_nbytes,
    output req_dev_add, req_reg, req_wdata,
    output m_ready, m_done, m_ack, m_rdata,
    input  req_grant, req_ack, req_done,
    input  req_err, rd_data,
    input  m_go, m_rw, m_nbytes, m_dev_add,
    input  m_reg, m_wdata, m_stop
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot winner, first
// requester at or after ptr, searching cyclically.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt
);

  logic [2*N_REQ-1:0] rot;
  logic [2*N_REQ-1:0] gdbl;
  logic [N_REQ-1:0]   first;
  logic               found;

  // Rotate so ptr sits at bit 0, pick lowest, rotate back.
  always_comb begin
    rot   = {req, req} >> ptr;
    first = '0;
    found = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && rot[j]) begin
        first[j] = 1'b1;
        found    = 1'b1;
      end
    end
    gdbl = {{N_REQ{1'b0}}, first} << ptr;
    gnt  = gdbl[N_REQ-1:0] | gdbl[2*N_REQ-1:N_REQ];
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin, per-transaction sharing of one I2C master
// engine between N_REQ controllers, with a hang watchdog.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 65535,
  parameter int TW          = 16
) (
  input logic                  clk,
  input logic                  reset,
  i2c_master_arbiter_if.master bus
);

  localparam int PW = $clog2(N_REQ);

  state_t           state, state_nx;
  logic [N_REQ-1:0] grant, grant_nx, pick;
  logic [PW-1:0]    own, own_nx, pick_idx;
  logic [PW-1:0]    ptr, ptr_nx;
  logic [TW-1:0]    wd, wd_nx;
  logic             go_q, stop_q, done_q, err_q;
  logic             go_nx, stop_nx, done_nx, err_nx;
  logic             busy;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .PW   (PW)
  ) u_rr (
    .req(bus.req_go),
    .ptr(ptr),
    .gnt(pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      grant  <= '0;
      own    <= '0;
      ptr    <= '0;
      wd     <= '0;
      go_q   <= 1'b0;
      stop_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      own    <= own_nx;
      ptr    <= ptr_nx;
      wd     <= wd_nx;
      go_q   <= go_nx;
      stop_q <= stop_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    own_nx   = own;
    ptr_nx   = ptr;
    wd_nx    = wd;
    go_nx    = 1'b0;
    stop_nx  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req_go) state_nx = GRANT;
      end
      GRANT: begin
        if (|pick) begin
          grant_nx = pick;
          own_nx   = pick_idx;
          state_nx = WAIT_RDY;
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT_RDY: begin
        if (!(|(bus.req_go & grant))) begin
          grant_nx = '0;
          state_nx = IDLE;
        end else if (bus.m_ready) begin
          go_nx    = 1'b1;
          wd_nx    = '0;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        wd_nx = bus.m_ack ? '0 : wd + TW'(1);
        // Completion takes priority over a coincident expiry.
        if (bus.m_done) begin
          done_nx  = 1'b1;
          state_nx = RELEASE;
        end else if (wd == TW'(TIMEOUT_CYC)) begin
          stop_nx  = 1'b1;
          done_nx  = 1'b1;
          err_nx   = 1'b1;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        ptr_nx   = (own == PW'(N_REQ - 1)) ? '0 : own + PW'(1);
        grant_nx = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy          = (state == BUSY);
  assign bus.req_grant = grant;
  assign bus.req_ack   = grant & {N_REQ{bus.m_ack & busy}};
  assign bus.req_done  = grant & {N_REQ{done_q}};
  assign bus.req_err   = grant & {N_REQ{err_q}};
  assign bus.rd_data   = bus.m_rdata;
  assign bus.m_go      = go_q;
  assign bus.m_stop    = stop_q;

  always_comb begin
    bus.m_rw      = MODE_WRITE;
    bus.m_nbytes  = '0;
    bus.m_dev_add = '0;
    bus.m_reg     = '0;
    bus.m_wdata   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        bus.m_rw      = bus.req_rw[i];
        bus.m_nbytes  = bus.req_nbytes[i*NB_W +: NB_W];
        bus.m_dev_add = bus.req_dev_add[i*DA_W +: DA_W];
        bus.m_reg     = bus.req_reg[i*BYTE_W +: BYTE_W];
        bus.m_wdata   = bus.req_wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: cycle table, corner sequences
// and a random run against a transaction-level model.
module tb_i2c_master_arbiter;
  import i2c_arb_pkg::*;

  localparam int N  = 2;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_master_arbiter_if #(.N_REQ(N)) bus ();

  i2c_master_arbiter #(
    .N_REQ      (N),
    .TIMEOUT_CYC(TO),
    .TW         (16)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] go;
    logic       rdy;
    logic       ack;
    logic       done;
    logic [1:0] grant;
    logic       mgo;
    logic [1:0] rack;
    logic [1:0] rdone;
    logic [6:0] dev;
    logic [5:0] nb;
  } vec_t;

  vec_t tv[12];

  logic       rw_a[N];
  logic [5:0] nb_a[N];
  logic [6:0] da_a[N];
  logic [7:0] rg_a[N];
  logic [7:0] wd_a[N];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] oh(input int i);
    logic [1:0] one;
    one = 2'b01;
    if (i < 0) return 2'b00;
    return one << i;
  endfunction

  function automatic int rr_pick(input logic [1:0] r, input int p);
    int w;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (w < 0 && r[j]) w = j;
    end
    return w;
  endfunction

  task automatic set_req(input int i, input logic rw,
                         input logic [5:0] nb, input logic [6:0] da,
                         input logic [7:0] rg, input logic [7:0] wd);
    rw_a[i] = rw; nb_a[i] = nb; da_a[i] = da;
    rg_a[i] = rg; wd_a[i] = wd;
    bus.req_rw[i]                   = rw;
    bus.req_nbytes[i*NB_W +: NB_W]  = nb;
    bus.req_dev_add[i*DA_W +: DA_W] = da;
    bus.req_reg[i*8 +: 8]           = rg;
    bus.req_wdata[i*8 +: 8]         = wd;
  endtask

  task automatic new_fields(input int i);
    set_req(i, 1'($urandom_range(0, 1)),
            6'($urandom_range(1, 63)), 7'($urandom),
            8'($urandom), 8'($urandom));
  endtask

  task automatic clr_bus();
    bus.req_go  = '0;
    bus.m_ready = 1'b0;
    bus.m_done  = 1'b0;
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
    for (int i = 0; i < N; i++)
      set_req(i, 1'b0, 6'd0, 7'd0, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_bus();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fields_std();
    set_req(0, MODE_WRITE, 6'd3, 7'h27, 8'h10, 8'h55);
    set_req(1, MODE_READ,  6'd9, 7'h3c, 8'h20, 8'haa);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  int   ptr_m, own_m, anchor, n_strobe, n_grant;
  bit   busy_m, strobe_q, err_q, old_strobe;
  bit   eng_busy, hang;
  int   eng_tgt, eng_acks;
  logic [1:0] go_prev, gr_prev, hold, ack_prev;
  logic seen;

  initial begin
    // reset state, with nonzero requester fields
    rst_n = 1'b0;
    clr_bus();
    fields_std();
    #1;
    chk("rst_grant", bus.req_grant, 0);
    chk("rst_mgo", bus.m_go, 0);
    chk("rst_mstop", bus.m_stop, 0);
    chk("rst_done", bus.req_done, 0);
    chk("rst_err", bus.req_err, 0);
    chk("rst_mdev", bus.m_dev_add, 0);
    chk("rst_mnb", bus.m_nbytes, 0);

    // single write transaction, cycle by cycle
    tv[0]  = '{2'b01, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 7'h00, 6'd0};
    tv[1]  = '{2'b01, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 7'h00, 6'd0};
    tv[2]  = '{2'b01, 1, 1, 0, 2'b01, 0, 2'b00, 2'b00, 7'h27, 6'd3};
    tv[3]  = '{2'b01, 1, 0, 0, 2'b01, 1, 2'b00, 2'b00, 7'h27, 6'd3};
    tv[4]  = '{2'b01, 0, 1, 0, 2'b01, 0, 2'b01, 2'b00, 7'h27, 6'd3};
    tv[5]  = '{2'b01, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 7'h27, 6'd3};
    tv[6]  = '{2'b01, 0, 1, 0, 2'b01, 0, 2'b01, 2'b00, 7'h27, 6'd3};
    tv[7]  = '{2'b01, 0, 1, 0, 2'b01, 0, 2'b01, 2'b00, 7'h27, 6'd3};
    tv[8]  = '{2'b01, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 7'h27, 6'd3};
    tv[9]  = '{2'b00, 1, 1, 0, 2'b01, 0, 2'b00, 2'b01, 7'h27, 6'd3};
    tv[10] = '{2'b00, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 7'h00, 6'd0};
    tv[11] = '{2'b00, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 7'h00, 6'd0};

    do_reset();
    fields_std();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      bus.req_go  = tv[i].go;
      bus.m_ready = tv[i].rdy;
      bus.m_ack   = tv[i].ack;
      bus.m_done  = tv[i].done;
      #1;
      chk($sformatf("t1_grant[%0d]", i), bus.req_grant, tv[i].grant);
      chk($sformatf("t1_mgo[%0d]", i), bus.m_go, tv[i].mgo);
      chk($sformatf("t1_ack[%0d]", i), bus.req_ack, tv[i].rack);
      chk($sformatf("t1_done[%0d]", i), bus.req_done, tv[i].rdone);
      chk($sformatf("t1_dev[%0d]", i), bus.m_dev_add, tv[i].dev);
      chk($sformatf("t1_nb[%0d]", i), bus.m_nbytes, tv[i].nb);
    end

    // contention and fairness
    do_reset();
    fields_std();
    bus.m_ready = 1'b1;
    bus.req_go  = 2'b11;
    tick(); tick();
    chk("con_g0", bus.req_grant, 2'b01);
    tick();
    chk("con_go0", bus.m_go, 1);
    chk("con_dev0", bus.m_dev_add, 7'h27);
    tick(); bus.m_done = 1'b1;
    tick(); bus.m_done = 1'b0; #1;
    chk("con_d0", bus.req_done, 2'b01);
    bus.req_go = 2'b10;
    tick(); bus.req_go = 2'b11;
    tick(); tick();
    chk("con_g1", bus.req_grant, 2'b10);
    tick();
    chk("con_go1", bus.m_go, 1);
    chk("con_dev1", bus.m_dev_add, 7'h3c);
    tick(); bus.m_done = 1'b1;
    tick(); bus.m_done = 1'b0; #1;
    chk("con_d1", bus.req_done, 2'b10);
    bus.req_go = 2'b01;
    tick(); tick(); tick();
    chk("con_g2", bus.req_grant, 2'b01);

    // read data routing to requester 1
    do_reset();
    fields_std();
    bus.m_ready = 1'b1;
    bus.req_go  = 2'b10;
    tick(); tick();
    chk("rd_grant", bus.req_grant, 2'b10);
    tick();
    chk("rd_mgo", bus.m_go, 1);
    chk("rd_rw", bus.m_rw, MODE_READ);
    tick();
    bus.m_ack = 1'b1; bus.m_rdata = 8'ha5; #1;
    chk("rd_ack", bus.req_ack, 2'b10);
    chk("rd_data", bus.rd_data, 8'ha5);
    tick();
    bus.m_ack = 1'b0; bus.m_done = 1'b1;
    tick(); bus.m_done = 1'b0; #1;
    chk("rd_done", bus.req_done, 2'b10);

    // watchdog expiry
    do_reset();
    fields_std();
    bus.m_ready = 1'b1;
    bus.req_go  = 2'b01;
    tick(); tick(); tick();
    chk("to_mgo", bus.m_go, 1);
    repeat (TO) tick();
    chk("to_pre_done", bus.req_done, 0);
    chk("to_pre_stop", bus.m_stop, 0);
    tick();
    chk("to_stop", bus.m_stop, 1);
    chk("to_done", bus.req_done, 2'b01);
    chk("to_err", bus.req_err, 2'b01);
    bus.req_go = 2'b00;
    tick();
    chk("to_stop_end", bus.m_stop, 0);
    chk("to_err_end", bus.req_err, 0);

    // m_done on the expiry cycle wins
    do_reset();
    fields_std();
    bus.m_ready = 1'b1;
    bus.req_go  = 2'b01;
    tick(); tick(); tick();
    repeat (TO) tick();
    bus.m_done = 1'b1;
    tick(); bus.m_done = 1'b0; #1;
    chk("tod_done", bus.req_done, 2'b01);
    chk("tod_err", bus.req_err, 0);
    chk("tod_stop", bus.m_stop, 0);

    // withdraw before issue
    do_reset();
    fields_std();
    bus.req_go = 2'b10;
    tick(); tick();
    chk("wd_grant", bus.req_grant, 2'b10);
    bus.req_go = 2'b00;
    tick();
    bus.m_ready = 1'b1; #1;
    chk("wd_clear", bus.req_grant, 0);
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | bus.m_go | (|bus.req_done);
    end
    chk("wd_nogo", seen, 0);
    bus.req_go = 2'b11;
    tick(); tick();
    chk("wd_ptr", bus.req_grant, 2'b01);

    // asynchronous reset in BUSY
    do_reset();
    fields_std();
    bus.m_ready = 1'b1;
    bus.req_go  = 2'b01;
    tick(); tick(); tick();
    tick(); bus.m_done = 1'b1;
    tick(); bus.m_done = 1'b0; bus.req_go = 2'b10;
    tick(); tick(); tick();
    chk("rb_grant1", bus.req_grant, 2'b10);
    tick();
    chk("rb_mgo", bus.m_go, 1);
    tick();
    bus.m_ack = 1'b1;
    rst_n = 1'b0; #1;
    chk("rb_grant", bus.req_grant, 0);
    chk("rb_ack", bus.req_ack, 0);
    chk("rb_mdev", bus.m_dev_add, 0);
    chk("rb_mgo0", bus.m_go, 0);
    bus.m_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_go = 2'b11;
    tick(); tick();
    chk("rb_regrant", bus.req_grant, 2'b01);

    // random run against transaction-level model
    do_reset();
    for (int i = 0; i < N; i++) new_fields(i);
    ptr_m = 0; own_m = 0; anchor = 0;
    n_strobe = 0; n_grant = 0;
    busy_m = 0; strobe_q = 0; err_q = 0;
    eng_busy = 0; hang = 0; eng_tgt = 0; eng_acks = 0;
    go_prev = '0; gr_prev = '0; hold = '0; ack_prev = '0;
    for (int t = 0; t < 4000; t++) begin
      if (t > 0) tick();
      for (int i = 0; i < N; i++) begin
        if (bus.req_done[i]) begin
          bus.req_go[i] = 1'b0;
          hold[i] = 1'b1;
        end else if (!bus.req_go[i]) begin
          if (hold[i]) hold[i] = 1'b0;
          else if ($urandom_range(0, 3) == 0) begin
            new_fields(i);
            bus.req_go[i] = 1'b1;
          end
        end
        if (ack_prev[i])
          set_req(i, rw_a[i], nb_a[i], da_a[i], rg_a[i], 8'($urandom));
      end
      bus.m_ack   = 1'b0;
      bus.m_done  = 1'b0;
      bus.m_rdata = 8'($urandom);
      if (eng_busy) begin
        if (bus.m_stop) eng_busy = 0;
        else if (!hang) begin
          if (eng_acks >= eng_tgt && $urandom_range(0, 1) == 1) begin
            bus.m_done = 1'b1;
            eng_busy = 0;
          end else if ($urandom_range(0, 2) == 0) begin
            bus.m_ack = 1'b1;
            eng_acks++;
          end
        end
      end
      if (bus.m_go) begin
        eng_busy = 1;
        hang     = ($urandom_range(0, 7) == 0);
        eng_tgt  = $urandom_range(1, 3);
        eng_acks = 0;
      end
      bus.m_ready = !eng_busy && ($urandom_range(0, 3) != 0);
      #1;
      old_strobe = strobe_q;
      chk("rnd_done", bus.req_done, strobe_q ? oh(own_m) : 2'b00);
      chk("rnd_err", bus.req_err, err_q ? oh(own_m) : 2'b00);
      chk("rnd_stop", bus.m_stop, err_q);
      if (gr_prev == 2'b00 && bus.req_grant != 2'b00) begin
        own_m = rr_pick(go_prev, ptr_m);
        chk("rnd_grant", bus.req_grant, oh(own_m));
        n_grant++;
      end
      if (bus.m_go) begin
        chk("rnd_mdev", bus.m_dev_add, da_a[own_m]);
        chk("rnd_mnb", bus.m_nbytes, nb_a[own_m]);
        chk("rnd_mrw", bus.m_rw, rw_a[own_m]);
        chk("rnd_mreg", bus.m_reg, rg_a[own_m]);
        chk("rnd_mwd", bus.m_wdata, wd_a[own_m]);
        busy_m = 1;
        anchor = t;
      end
      chk("rnd_ack", bus.req_ack,
          (busy_m && bus.m_ack) ? oh(own_m) : 2'b00);
      if (busy_m && bus.m_ack)
        chk("rnd_rdata", bus.rd_data, bus.m_rdata);
      ack_prev = bus.req_ack;
      strobe_q = 0;
      err_q    = 0;
      if (old_strobe) begin
        ptr_m = (own_m + 1) % N;
        n_strobe++;
      end
      if (busy_m) begin
        if (bus.m_done) begin
          strobe_q = 1; busy_m = 0;
        end else if (t == anchor + TO) begin
          strobe_q = 1; err_q = 1; busy_m = 0;
        end else if (bus.m_ack) begin
          anchor = t + 1;
        end
      end
      go_prev = bus.req_go;
      gr_prev = bus.req_grant;
    end
    chk("rnd_activity", (n_strobe > 50 && n_grant > 50), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
